konix_load_arbiter: RTL and testbench

KONIX_LOAD_ARBITER -- requirements
Module: konix_load_arbiter

---
 rtl/konix_pkg.sv | 16 +
 rtl/konix_ioctl_buf.sv | 39 +++
 rtl/konix_load_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_konix_load_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/konix_pkg.sv
// Shared types and defaults for the Konix download/CPU RAM arbiter.
package konix_pkg;

    localparam logic [7:0] LOAD_INDEX_DEF = 8'd4;
    localparam int unsigned IOCTL_AW = 27;

    typedef enum logic [2:0] {
        IDLE,
        CPU_ACC,
        CPU_ACK,
        LOAD,
        LOAD_WR,
        HOLD
    } state_e;

endpackage

// File: rtl/konix_ioctl_buf.sv
// One-entry holding register for a download byte and its file offset.
module konix_ioctl_buf
    import konix_pkg::*;
(
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                capture_i,
    input  logic [IOCTL_AW-1:0] addr_i,
    input  logic [7:0]          data_i,
    input  logic                release_i,
    output logic                full_o,
    output logic [IOCTL_AW-1:0] addr_o,
    output logic [7:0]          data_o
);

    logic                full_q;
    logic [IOCTL_AW-1:0] addr_q;
    logic [7:0]          data_q;

    // A capture in the release cycle wins so back-to-back bytes are not lost.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (capture_i) begin
            full_q <= 1'b1;
            addr_q <= addr_i;
            data_q <= data_i;
        end else if (release_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o = full_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/konix_load_arbiter.sv
// Shares one RAM port between the Konix CPU and the HPS file download,
// holding the machine in reset while a download is in progress.
//   state   | meaning
//   IDLE    | no access; download start has priority over CPU request
//   CPU_ACC | RAM cycle for the CPU access in flight
//   CPU_ACK | ack pulse, read data taken straight from the RAM
//   LOAD    | download active, waiting for a buffered byte
//   LOAD_WR | RAM write of the buffered byte
//   HOLD    | download done, sys_hold kept for HOLD_CYCLES
module konix_load_arbiter
    import konix_pkg::*;
#(
    parameter logic [7:0]        LOAD_INDEX  = LOAD_INDEX_DEF,
    parameter int                RAM_AW      = 20,
    parameter logic [RAM_AW-1:0] LOAD_BASE   = '0,
    parameter int                HOLD_CYCLES = 16
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                ioctl_download,
    input  logic [15:0]         ioctl_index,
    input  logic                ioctl_wr,
    input  logic [26:0]         ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    output logic                ioctl_wait,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [RAM_AW-1:0]   cpu_addr,
    input  logic [7:0]          cpu_wdata,
    output logic                cpu_ack,
    output logic [7:0]          cpu_rdata,
    output logic                ram_ce,
    output logic                ram_we,
    output logic [RAM_AW-1:0]   ram_addr,
    output logic [7:0]          ram_wdata,
    input  logic [7:0]          ram_rdata,
    output logic                sys_hold,
    output logic [26:0]         load_count,
    output logic                load_ovf
);

    localparam int HCW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HCW-1:0] HOLD_INIT = HCW'(HOLD_CYCLES - 1);

    state_e              state_q, state_d;
    logic                sys_hold_q, sys_hold_d;
    logic [HCW-1:0]      hold_cnt_q, hold_cnt_d;
    logic                ram_ce_q, ram_ce_d;
    logic                ram_we_q, ram_we_d;
    logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
    logic [7:0]          ram_wdata_q, ram_wdata_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic [26:0]         load_count_q, load_count_d;
    logic                load_ovf_q, load_ovf_d;

    logic                dl_active;
    logic                buf_full;
    logic                buf_release;
    logic [26:0]         buf_addr;
    logic [7:0]          buf_data;
    logic [27:0]         load_sum;
    logic                load_oob;
    logic                unused_idx;

    assign dl_active  = ioctl_download && (ioctl_index[7:0] == LOAD_INDEX);
    assign unused_idx = ^ioctl_index[15:8];

    konix_ioctl_buf u_buf (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .capture_i (dl_active && ioctl_wr),
        .addr_i    (ioctl_addr),
        .data_i    (ioctl_dout),
        .release_i (buf_release),
        .full_o    (buf_full),
        .addr_o    (buf_addr),
        .data_o    (buf_data)
    );

    // One extra bit so a base near the top of RAM cannot wrap silently.
    assign load_sum = 28'(LOAD_BASE) + {1'b0, buf_addr};
    assign load_oob = (load_sum >> RAM_AW) != 28'd0;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sys_hold_q   <= 1'b1;
            hold_cnt_q   <= '0;
            ram_ce_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            load_count_q <= '0;
            load_ovf_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sys_hold_q   <= sys_hold_d;
            hold_cnt_q   <= hold_cnt_d;
            ram_ce_q     <= ram_ce_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            cpu_ack_q    <= cpu_ack_d;
            load_count_q <= load_count_d;
            load_ovf_q   <= load_ovf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sys_hold_d   = sys_hold_q;
        hold_cnt_d   = hold_cnt_q;
        ram_ce_d     = 1'b0;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        cpu_ack_d    = 1'b0;
        load_count_d = load_count_q;
        load_ovf_d   = load_ovf_q;
        buf_release  = 1'b0;
        unique case (state_q)
            IDLE: begin
                sys_hold_d = 1'b0;
                if (dl_active) begin
                    state_d      = LOAD;
                    sys_hold_d   = 1'b1;
                    load_count_d = '0;
                    load_ovf_d   = 1'b0;
                end else if (cpu_req) begin
                    state_d     = CPU_ACC;
                    ram_ce_d    = 1'b1;
                    ram_we_d    = cpu_we;
                    ram_addr_d  = cpu_addr;
                    ram_wdata_d = cpu_wdata;
                end
            end
            CPU_ACC: begin
                state_d   = CPU_ACK;
                cpu_ack_d = 1'b1;
            end
            CPU_ACK: state_d = IDLE;
            LOAD: begin
                if (buf_full) begin
                    state_d     = LOAD_WR;
                    buf_release = 1'b1;
                    if (load_oob) begin
                        load_ovf_d = 1'b1;
                    end else begin
                        ram_ce_d     = 1'b1;
                        ram_we_d     = 1'b1;
                        ram_addr_d   = load_sum[RAM_AW-1:0];
                        ram_wdata_d  = buf_data;
                        load_count_d = load_count_q + 27'd1;
                    end
                end else if (!dl_active) begin
                    state_d    = HOLD;
                    hold_cnt_d = HOLD_INIT;
                end
            end
            LOAD_WR: state_d = LOAD;
            HOLD: begin
                // A restart here is a new download: counters start over.
                if (dl_active) begin
                    state_d      = LOAD;
                    load_count_d = '0;
                    load_ovf_d   = 1'b0;
                end else if (hold_cnt_q == '0) begin
                    state_d    = IDLE;
                    sys_hold_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ioctl_wait = buf_full;
    assign cpu_ack    = cpu_ack_q;
    assign cpu_rdata  = cpu_ack_q ? ram_rdata : 8'h00;
    assign ram_ce     = ram_ce_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign sys_hold   = sys_hold_q;
    assign load_count = load_count_q;
    assign load_ovf   = load_ovf_q;

endmodule

// File: tb/tb_konix_load_arbiter.sv
// Randomised bench for konix_load_arbiter against a simple RAM and download model.
module tb_konix_load_arbiter;

    localparam int          RAM_AW = 20;
    localparam logic [19:0] BASE   = 20'h00100;
    localparam int          HOLD_N = 16;

    typedef struct {
        logic [19:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [15:0] ioctl_index = 16'h0;
    logic        ioctl_wr = 1'b0;
    logic [26:0] ioctl_addr = 27'h0;
    logic [7:0]  ioctl_dout = 8'h0;
    logic        ioctl_wait;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [19:0] cpu_addr = 20'h0;
    logic [7:0]  cpu_wdata = 8'h0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        ram_ce, ram_we;
    logic [19:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h0;
    logic        sys_hold;
    logic [26:0] load_count;
    logic        load_ovf;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wait_hi = 0;
    int hold_lo = 0;
    int ack_n = 0;

    logic [7:0]  mem [0:(1<<RAM_AW)-1];
    logic [7:0]  ref_mem [int];
    wr_t         wlog[$];
    wr_t         wr_e;
    logic [26:0] dl_off[$];
    logic [7:0]  dl_dat[$];

    always #5 clk_sys = ~clk_sys;

    konix_load_arbiter #(
        .LOAD_INDEX(8'd4), .RAM_AW(RAM_AW), .LOAD_BASE(BASE), .HOLD_CYCLES(HOLD_N)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .sys_hold(sys_hold), .load_count(load_count), .load_ovf(load_ovf)
    );

    // Synchronous RAM with one cycle read latency; every write is logged.
    always @(posedge clk_sys) begin
        cyc <= cyc + 1;
        if (ram_ce) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                wr_e.a = ram_addr;
                wr_e.d = ram_wdata;
                wlog.push_back(wr_e);
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    always @(negedge clk_sys) begin
        if (ioctl_wait) wait_hi++;
        if (!sys_hold) hold_lo++;
        if (cpu_ack) ack_n++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic cpu_access(input logic we, input logic [19:0] a, input logic [7:0] wd,
                              output int lat, output logic [7:0] rd);
        cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1; lat = 0;
        while (lat < 40) begin
            tick(); lat++;
            if (cpu_ack) break;
        end
        rd = cpu_rdata;
        if (!cpu_ack) lat = -1;
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [26:0] off, input logic [7:0] d);
        int n = 0;
        while (ioctl_wait && n < 50) begin tick(); n++; end
        total++;
        if (n >= 50) begin bad++; $display("FAIL send_byte: ioctl_wait stuck got=1 exp=0"); end
        ioctl_wr = 1'b1; ioctl_addr = off; ioctl_dout = d;
        tick();
        ioctl_wr = 1'b0;
    endtask

    // exp_cnt: -1 = count from model, -2 = do not check count
    task automatic check_download(input int exp_wait, input bit cpu_pend, input int exp_cnt);
        wr_t exp[$];
        wr_t e;
        int  ecnt = 0;
        bit  eovf = 0;
        int  hold_n = 0;
        int  fall_cyc;
        int  n;
        foreach (dl_off[i]) begin
            longint a = longint'(BASE) + longint'(dl_off[i]);
            if (a < (longint'(1) << RAM_AW)) begin
                e.a = 20'(a); e.d = dl_dat[i]; exp.push_back(e); ecnt++;
            end else begin
                eovf = 1;
            end
        end
        if (exp_cnt >= 0) ecnt = exp_cnt;
        repeat (4) tick();
        ioctl_download = 1'b0;
        for (n = 0; n < 100; n++) begin
            tick();
            if (sys_hold) hold_n++; else break;
        end
        fall_cyc = cyc;
        total++;
        if (hold_n != HOLD_N) begin bad++; $display("FAIL hold_cycles got=%0d exp=%0d", hold_n, HOLD_N); end
        total++;
        if (wlog.size() != exp.size()) begin
            bad++; $display("FAIL write_count got=%0d exp=%0d", wlog.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                total++;
                if (wlog[i].a !== exp[i].a || wlog[i].d !== exp[i].d) begin
                    bad++;
                    $display("FAIL ram_write[%0d] got=%05h/%02h exp=%05h/%02h", i, wlog[i].a, wlog[i].d, exp[i].a, exp[i].d);
                end
            end
        end
        if (exp_cnt != -2) begin
            total++;
            if (load_count !== 27'(ecnt)) begin bad++; $display("FAIL load_count got=%0d exp=%0d", load_count, ecnt); end
        end
        total++;
        if (load_ovf !== eovf) begin bad++; $display("FAIL load_ovf got=%0b exp=%0b", load_ovf, eovf); end
        if (exp_wait >= 0) begin
            total++;
            if (wait_hi != exp_wait) begin bad++; $display("FAIL wait_cycles got=%0d exp=%0d", wait_hi, exp_wait); end
        end
        if (cpu_pend) begin
            total++;
            if (ack_n != 0) begin bad++; $display("FAIL ack_during_load got=%0d exp=0", ack_n); end
            n = 0;
            while (!cpu_ack && n < 20) begin tick(); n++; end
            total++;
            if (cpu_ack !== 1'b1 || cyc - fall_cyc != 2 || cpu_rdata !== 8'h5A) begin
                bad++;
                $display("FAIL cpu_after_hold got=ack%0b/lat%0d/%02h exp=ack1/lat2/5a", cpu_ack, cyc - fall_cyc, cpu_rdata);
            end
            cpu_req = 1'b0;
            tick();
        end
        tick();
    endtask

    task automatic run_download(input bit cpu_pend);
        wlog.delete(); wait_hi = 0; ack_n = 0;
        ioctl_index = 16'h0004; ioctl_download = 1'b1;
        tick();
        if (cpu_pend) begin cpu_we = 1'b0; cpu_addr = 20'h01234; cpu_req = 1'b1; end
        foreach (dl_off[i]) send_byte(dl_off[i], dl_dat[i]);
        check_download(dl_off.size(), cpu_pend, -1);
    endtask

    task automatic test_reset();
        logic [68:0] got;
        repeat (2) tick();
        got = {sys_hold, ioctl_wait, cpu_ack, ram_ce, ram_we, ram_addr, ram_wdata, cpu_rdata, load_count, load_ovf};
        total++;
        if (got !== {1'b1, 68'h0}) begin bad++; $display("FAIL reset_values got=%h exp=%h", got, {1'b1, 68'h0}); end
        reset_n = 1'b1;
        tick();
        total++;
        if (sys_hold !== 1'b0) begin bad++; $display("FAIL sys_hold_release got=%0b exp=0", sys_hold); end
    endtask

    task automatic test_cpu_read();
        mem[20'h01234] = 8'h5A; ref_mem[32'h01234] = 8'h5A;
        cpu_we = 1'b0; cpu_addr = 20'h01234; cpu_req = 1'b1;
        tick();
        total++;
        if (ram_ce !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 20'h01234 || cpu_ack !== 1'b0) begin
            bad++; $display("FAIL cpu_read_cycle1 got=ce%0b we%0b %05h ack%0b exp=ce1 we0 01234 ack0", ram_ce, ram_we, ram_addr, cpu_ack);
        end
        tick();
        total++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h5A) begin
            bad++; $display("FAIL cpu_read_cycle2 got=ack%0b %02h exp=ack1 5a", cpu_ack, cpu_rdata);
        end
        cpu_req = 1'b0;
        tick();
        total++;
        if (cpu_ack !== 1'b0 || ram_ce !== 1'b0) begin bad++; $display("FAIL cpu_ack_pulse got=ack%0b ce%0b exp=0 0", cpu_ack, ram_ce); end
    endtask

    task automatic test_cpu_random();
        logic [19:0] addrs[8];
        int          lat;
        logic [7:0]  rd, wd;
        foreach (addrs[i]) begin
            addrs[i] = 20'h20000 + 20'($urandom_range(0, 20'h3FFFF));
            wd = 8'($urandom);
            ref_mem[int'(addrs[i])] = wd;
            cpu_access(1'b1, addrs[i], wd, lat, rd);
            total++;
            if (lat != 2) begin bad++; $display("FAIL cpu_write_latency got=%0d exp=2", lat); end
        end
        for (int k = 0; k < 8; k++) begin
            int j = $urandom_range(0, 7);
            cpu_access(1'b0, addrs[j], 8'h00, lat, rd);
            total++;
            if (lat != 2 || rd !== ref_mem[int'(addrs[j])]) begin
                bad++; $display("FAIL cpu_read_random got=lat%0d/%02h exp=lat2/%02h", lat, rd, ref_mem[int'(addrs[j])]);
            end
        end
    endtask

    task automatic test_download_basic();
        dl_off = '{27'd0, 27'd1, 27'd2};
        dl_dat = '{8'h11, 8'h22, 8'h33};
        run_download(1'b0);
    endtask

    task automatic test_cpu_blocked();
        dl_off.delete(); dl_dat.delete();
        repeat (3) begin
            dl_off.push_back(27'($urandom_range(0, 27'hFFF)));
            dl_dat.push_back(8'($urandom));
        end
        run_download(1'b1);
    endtask

    task automatic test_cpu_before_load();
        logic [7:0] d = 8'($urandom);
        wlog.delete(); ack_n = 0;
        cpu_we = 1'b0; cpu_addr = 20'h01234; cpu_req = 1'b1;
        tick();
        ioctl_index = 16'h0004; ioctl_download = 1'b1;
        ioctl_wr = 1'b1; ioctl_addr = 27'd7; ioctl_dout = d;
        tick();
        ioctl_wr = 1'b0;
        total++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h5A) begin
            bad++; $display("FAIL cpu_before_load got=ack%0b %02h exp=ack1 5a", cpu_ack, cpu_rdata);
        end
        cpu_req = 1'b0;
        dl_off = '{27'd7}; dl_dat = '{d};
        check_download(-1, 1'b0, -1);
    endtask

    task automatic test_overflow();
        dl_off = '{27'hFFEFF, 27'hFFF00};
        dl_dat = '{8'($urandom), 8'($urandom)};
        run_download(1'b0);
    endtask

    task automatic test_random_download();
        repeat (2) begin
            int nb = $urandom_range(4, 9);
            dl_off.delete(); dl_dat.delete();
            repeat (nb) begin
                if ($urandom_range(0, 1) == 0) dl_off.push_back(27'($urandom_range(0, 27'hFF)));
                else dl_off.push_back(27'($urandom_range(27'hFFEF0, 27'hFFF10)));
                dl_dat.push_back(8'($urandom));
            end
            run_download(1'b0);
        end
    endtask

    task automatic test_hold_restart();
        logic [7:0] d1 = 8'($urandom);
        logic [7:0] d2 = 8'($urandom);
        wlog.delete();
        ioctl_index = 16'h0004; ioctl_download = 1'b1;
        tick();
        send_byte(27'd5, d1);
        repeat (4) tick();
        hold_lo = 0;
        ioctl_download = 1'b0;
        repeat (6) tick();
        ioctl_download = 1'b1;
        tick();
        send_byte(27'd6, d2);
        total++;
        if (hold_lo != 0) begin bad++; $display("FAIL hold_restart_sys_hold got=%0d low cycles exp=0", hold_lo); end
        dl_off = '{27'd5, 27'd6}; dl_dat = '{d1, d2};
        check_download(-1, 1'b0, -2);
    endtask

    task automatic test_other_index();
        int         lat;
        logic [7:0] rd;
        wlog.delete(); wait_hi = 0; hold_lo = 0;
        ioctl_index = 16'h0002; ioctl_download = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) send_byte(27'(k), 8'($urandom));
        cpu_access(1'b0, 20'h01234, 8'h00, lat, rd);
        total++;
        if (lat != 2 || rd !== 8'h5A) begin bad++; $display("FAIL other_index_cpu got=lat%0d/%02h exp=lat2/5a", lat, rd); end
        total++;
        if (wlog.size() != 0 || wait_hi != 0) begin
            bad++; $display("FAIL other_index_ignored got=writes%0d wait%0d exp=0 0", wlog.size(), wait_hi);
        end
        total++;
        if (hold_lo < 6 || sys_hold !== 1'b0) begin bad++; $display("FAIL other_index_sys_hold got=%0b exp=0", sys_hold); end
        ioctl_download = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [7:0]  b[3];
        logic [68:0] got;
        foreach (b[i]) b[i] = 8'($urandom);
        wlog.delete();
        ioctl_index = 16'h0004; ioctl_download = 1'b1;
        tick();
        send_byte(27'd0, b[0]);
        repeat (2) tick();
        ioctl_wr = 1'b1; ioctl_addr = 27'd1; ioctl_dout = 8'hEE;
        tick();
        ioctl_wr = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        got = {sys_hold, ioctl_wait, cpu_ack, ram_ce, ram_we, ram_addr, ram_wdata, cpu_rdata, load_count, load_ovf};
        total++;
        if (got !== {1'b1, 68'h0}) begin bad++; $display("FAIL reset_mid_values got=%h exp=%h", got, {1'b1, 68'h0}); end
        tick();
        reset_n = 1'b1;
        tick();
        send_byte(27'd1, b[1]);
        send_byte(27'd2, b[2]);
        dl_off = '{27'd0, 27'd1, 27'd2}; dl_dat = '{b[0], b[1], b[2]};
        check_download(-1, 1'b0, 2);
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_cpu_random();
        test_download_basic();
        test_cpu_blocked();
        test_cpu_before_load();
        test_overflow();
        test_random_download();
        test_hold_restart();
        test_other_index();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
